// File: rtl/exe_stage_pkg.sv
// Shared types and sizing for the execute stage: opcodes, control states, datapath widths.
package exe_stage_pkg;

    localparam int DSIZE  = 16;
    localparam int ASIZE  = 5;
    localparam int OPSIZE = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_MUL = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes 8..15 decode as NOP; 0..6 complete in the combinational ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op < 4'd7);
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DSIZE bits of the unsigned product.
module mul_seq
    import exe_stage_pkg::*;
#(
    parameter int W = DSIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;

    // Operand capture on start, then one add/shift step per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {W{1'b0}};
            b_r    <= {W{1'b0}};
            acc_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            a_r    <= a;
            b_r    <= b;
            acc_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (b_r[0]) begin
                acc_r <= acc_r + a_r;
            end
            a_r   <= {a_r[W-2:0], 1'b0};
            b_r   <= {1'b0, b_r[W-1:1]};
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
            end
        end
    end

    // done flags the final step, so product is valid on the following cycle.
    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == CNT_LAST);
    assign product = acc_r;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU with operand-B mux, plus IDLE/BUSY/DONE control around mul_seq.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DW = DSIZE,
    parameter int AW = ASIZE,
    parameter int OW = OPSIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [OW-1:0] op_in,
    input  logic [DW-1:0] rs1_in,
    input  logic [DW-1:0] rs2_in,
    input  logic [DW-1:0] imm_in,
    input  logic          sel_imm,
    input  logic [AW-1:0] waddr_in,
    output logic [AW-1:0] waddr_out,
    output logic [DW-1:0] aluout_out,
    output logic          stall
);

    localparam int SHW = $clog2(DW);

    state_e        state_r;
    state_e        state_next_s;
    logic [AW-1:0] waddr_r;
    logic [DW-1:0] b_mux_s;
    logic [DW-1:0] alu_s;
    logic          start_s;
    logic          mul_busy_s;
    logic          mul_done_s;
    logic [DW-1:0] product_s;

    assign b_mux_s = sel_imm ? imm_in : rs2_in;

    // Single-cycle ALU result; MUL and NOP codes produce zero here.
    always_comb begin
        alu_s = {DW{1'b0}};
        case (op_in)
            OP_ADD:  alu_s = rs1_in + b_mux_s;
            OP_SUB:  alu_s = rs1_in - b_mux_s;
            OP_AND:  alu_s = rs1_in & b_mux_s;
            OP_OR:   alu_s = rs1_in | b_mux_s;
            OP_XOR:  alu_s = rs1_in ^ b_mux_s;
            OP_SLL:  alu_s = rs1_in << b_mux_s[SHW-1:0];
            OP_SRL:  alu_s = rs1_in >> b_mux_s[SHW-1:0];
            default: alu_s = {DW{1'b0}};
        endcase
    end

    mul_seq #(.W(DW)) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .a       (rs1_in),
        .b       (b_mux_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Control state and the destination register of the in-flight MUL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            waddr_r <= {AW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                waddr_r <= waddr_in;
            end else begin
                waddr_r <= waddr_r;
            end
        end
    end

    // Next state and output muxing; any cycle without a result is a bubble (waddr 0, data 0).
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        stall        = 1'b0;
        waddr_out    = {AW{1'b0}};
        aluout_out   = {DW{1'b0}};
        if (rst) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_in && (op_in == OW'(OP_MUL))) begin
                        stall        = 1'b1;
                        start_s      = 1'b1;
                        state_next_s = ST_BUSY;
                    end else if (valid_in && is_alu_op(4'(op_in)) && (waddr_in != {AW{1'b0}})) begin
                        waddr_out  = waddr_in;
                        aluout_out = alu_s;
                    end else begin
                        waddr_out  = {AW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    stall = 1'b1;
                    if (mul_done_s) begin
                        state_next_s = ST_DONE;
                    end else if (!mul_busy_s) begin
                        // Multiplier lost its operation; do not wait forever.
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                    waddr_out    = waddr_r;
                    if (waddr_r != {AW{1'b0}}) begin
                        aluout_out = product_s;
                    end else begin
                        aluout_out = {DW{1'b0}};
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: table of single-cycle vectors plus hand-written MUL/reset sequences.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  op_in;
    logic [15:0] rs1_in;
    logic [15:0] rs2_in;
    logic [15:0] imm_in;
    logic        sel_imm;
    logic [4:0]  waddr_in;
    logic [4:0]  waddr_out;
    logic [15:0] aluout_out;
    logic        stall;

    int checks = 0;
    int errors = 0;

    exe_stage dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .op_in      (op_in),
        .rs1_in     (rs1_in),
        .rs2_in     (rs2_in),
        .imm_in     (imm_in),
        .sel_imm    (sel_imm),
        .waddr_in   (waddr_in),
        .waddr_out  (waddr_out),
        .aluout_out (aluout_out),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        sel;
        logic [4:0]  wa;
        logic [4:0]  exp_wa;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm, input logic sel,
                         input logic [4:0] wa);
        valid_in = v; op_in = op; rs1_in = a; rs2_in = b;
        imm_in = imm; sel_imm = sel; waddr_in = wa;
    endtask

    task automatic check_out(input string name, input int ewa, input int eout, input int estall);
        check({name, ".waddr"}, int'(waddr_out), ewa);
        check({name, ".aluout"}, int'(aluout_out), eout);
        check({name, ".stall"}, int'(stall), estall);
    endtask

    // Issue a MUL, count stall cycles (bounded), then check the DONE cycle.
    task automatic run_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] wa, input logic [15:0] exp);
        int n;
        drive(1'b1, 4'd7, a, b, 16'h0000, 1'b0, wa);
        #1;
        n = 0;
        while (stall && n < 40) begin
            check({name, ".bubble_waddr"}, int'(waddr_out), 0);
            n++;
            @(negedge clk); #1;
        end
        check({name, ".stall_len"}, n, 17);
        check_out({name, ".done"}, int'(wa), (wa == 5'd0) ? 0 : int'(exp), 0);
    endtask

    initial begin
        vecs[0]  = '{"add_wrap",  1'b1, 4'd0, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 5'd3,  5'd3,  16'h0001};
        vecs[1]  = '{"sub_wrap",  1'b1, 4'd1, 16'h0005, 16'h0007, 16'h0000, 1'b0, 5'd1,  5'd1,  16'hFFFE};
        vecs[2]  = '{"and",       1'b1, 4'd2, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0, 5'd2,  5'd2,  16'hF000};
        vecs[3]  = '{"or",        1'b1, 4'd3, 16'hF0F0, 16'h0F00, 16'h0000, 1'b0, 5'd4,  5'd4,  16'hFFF0};
        vecs[4]  = '{"xor",       1'b1, 4'd4, 16'hFFFF, 16'h0F0F, 16'h0000, 1'b0, 5'd6,  5'd6,  16'hF0F0};
        vecs[5]  = '{"sll_imm",   1'b1, 4'd5, 16'h8001, 16'h0000, 16'h0011, 1'b1, 5'd7,  5'd7,  16'h0002};
        vecs[6]  = '{"srl_imm",   1'b1, 4'd6, 16'h8001, 16'h0000, 16'h0011, 1'b1, 5'd8,  5'd8,  16'h4000};
        vecs[7]  = '{"sll_15",    1'b1, 4'd5, 16'h0001, 16'h000F, 16'h0000, 1'b0, 5'd9,  5'd9,  16'h8000};
        vecs[8]  = '{"add_imm",   1'b1, 4'd0, 16'h0001, 16'h1000, 16'h0001, 1'b1, 5'd11, 5'd11, 16'h0002};
        vecs[9]  = '{"nop8",      1'b1, 4'd8, 16'h1234, 16'h1111, 16'h0000, 1'b0, 5'd10, 5'd0,  16'h0000};
        vecs[10] = '{"nop15",     1'b1, 4'hF, 16'h1234, 16'h1111, 16'h0000, 1'b0, 5'd12, 5'd0,  16'h0000};
        vecs[11] = '{"invalid",   1'b0, 4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 5'd3,  5'd0,  16'h0000};
        vecs[12] = '{"add_r0",    1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 5'd0,  5'd0,  16'h0000};

        rst = 1'b1;
        drive(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 5'd3);
        @(negedge clk); #1;
        check_out("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                  vecs[i].sel, vecs[i].wa);
            #1;
            check_out(vecs[i].name, int'(vecs[i].exp_wa), int'(vecs[i].exp_out), 0);
            @(negedge clk);
        end

        run_mul("mul_basic", 16'h0123, 16'h0045, 5'd5, 16'h4E6F);
        @(negedge clk);
        run_mul("mul_wrap", 16'hFFFF, 16'hFFFF, 5'd6, 16'h0001);
        @(negedge clk);
        run_mul("mul_r0", 16'h0003, 16'h0003, 5'd0, 16'h0009);
        @(negedge clk);

        // Reset at BUSY cnt=7 (cycle T+8) drops the MUL.
        drive(1'b1, 4'd7, 16'h0123, 16'h0045, 16'h0000, 1'b0, 5'd5);
        for (int i = 0; i < 8; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("rst_busy", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 5'd2);
        #1;
        check_out("add_after_rst", 2, 2, 0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0);
        #1;
        check_out("no_stale", 0, 0, 0);
        @(negedge clk);

        // Back-to-back MUL r1 then ADD r4: each result appears exactly once.
        run_mul("b2b_mul", 16'h0003, 16'h0004, 5'd1, 16'h000C);
        @(negedge clk);
        drive(1'b1, 4'd0, 16'h0002, 16'h0002, 16'h0000, 1'b0, 5'd4);
        #1;
        check_out("b2b_add", 4, 4, 0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0);
        #1;
        check_out("b2b_idle", 0, 0, 0);
        @(negedge clk);

        // Reset while in DONE suppresses the result.
        drive(1'b1, 4'd7, 16'h0002, 16'h0002, 16'h0000, 1'b0, 5'd7);
        for (int i = 0; i < 17; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("rst_done", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0);
        #1;
        check_out("after_rst_done", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
